// File: rtl/vscpu_ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous-read RAM.
// Round-robin on conflict, with an optional bounded lock so one master can
// keep the RAM for up to MAX_LOCK back-to-back accesses.
module vscpu_ram_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (CPU side)
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // master 1 (loader/debug side)
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // RAM port
  output logic              ram_wrEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LCNT_LAST = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_M0   = 2'd1,
    LK_M1   = 2'd2
  } lock_t;

  lock_t            lock_q;
  logic [CNT_W-1:0] lcnt_q;
  logic             rr_q;
  logic             rv0_q;
  logic             rv1_q;

  logic             gnt0;
  logic             gnt1;
  logic             win_lock;
  logic [CNT_W-1:0] run_cnt;

  // Grant decision: live lock owner first, then single requester, then rr.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (lock_q == LK_M0 && m0_req) begin
        gnt0 = 1'b1;
      end else if (lock_q == LK_M1 && m1_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        gnt0 = ~rr_q;
        gnt1 = rr_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  // Lock bookkeeping: a grant to a non-owner restarts the run count at zero.
  always_comb begin
    win_lock = 1'b0;
    run_cnt  = '0;
    if (gnt0) begin
      win_lock = m0_lock;
      run_cnt  = (lock_q == LK_M0) ? lcnt_q : '0;
    end else if (gnt1) begin
      win_lock = m1_lock;
      run_cnt  = (lock_q == LK_M1) ? lcnt_q : '0;
    end
  end

  // Arbitration state: rr pointer, lock owner and run counter, read tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= LK_NONE;
      lcnt_q <= '0;
      rr_q   <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      rv0_q <= gnt0 & ~m0_we;
      rv1_q <= gnt1 & ~m1_we;
      if (gnt0 || gnt1) begin
        rr_q <= gnt0;
      end
      if ((gnt0 || gnt1) && win_lock && (run_cnt < LCNT_LAST)) begin
        lock_q <= gnt0 ? LK_M0 : LK_M1;
        lcnt_q <= run_cnt + CNT_W'(1);
      end else begin
        lock_q <= LK_NONE;
        lcnt_q <= '0;
      end
    end
  end

  // RAM request mux driven by the winner; idle bus is all zero.
  always_comb begin
    ram_wrEn  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_wrEn  = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (gnt1) begin
      ram_wrEn  = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // Grants and read returns; read data is forced to zero unless tagged valid.
  always_comb begin
    m0_gnt    = gnt0;
    m1_gnt    = gnt1;
    m0_rvalid = rv0_q;
    m1_rvalid = rv1_q;
    m0_rdata  = rv0_q ? ram_rdata : '0;
    m1_rdata  = rv1_q ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_vscpu_ram_arbiter.sv
// Randomized bench for vscpu_ram_arbiter with a behavioural arbitration model,
// a behavioural RAM, and a few directed scenarios with literal expectations.
module tb_vscpu_ram_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int ML = 8;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          ram_wrEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  vscpu_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural synchronous-read RAM with a preload port.
  bit [DW-1:0]   mem [1 << AW];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wrEn) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          rr_m, own_m, cnt_m, win_m;
  bit          pv [2];
  logic [31:0] pd [2];
  logic [31:0] mmem [int];
  int          wt [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    rr_m = 0; own_m = -1; cnt_m = 0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    wt[0] = 0; wt[1] = 0;
  endtask

  function automatic int mdl_winner();
    bit r [2];
    r[0] = m0_req;
    r[1] = m1_req;
    if (!rst) return -1;
    if (own_m >= 0 && r[own_m]) return own_m;
    if (r[0] && r[1]) return rr_m;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  // Apply the model's rules for the clock edge that ends the current cycle.
  task automatic model_edge();
    int w, run;
    logic we, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = win_m;
    pv[0] = 1'b0; pv[1] = 1'b0;
    if (w < 0) begin
      own_m = -1; cnt_m = 0;
    end else begin
      we = (w == 0) ? m0_we : m1_we;
      lk = (w == 0) ? m0_lock : m1_lock;
      a  = (w == 0) ? m0_addr : m1_addr;
      d  = (w == 0) ? m0_wdata : m1_wdata;
      rr_m = 1 - w;
      if (we) mmem[int'(a)] = d;
      else begin
        pv[w] = 1'b1;
        pd[w] = mmem.exists(int'(a)) ? mmem[int'(a)] : 32'h0;
      end
      run = (own_m == w) ? cnt_m : 0;
      if (lk && (run + 1 < ML)) begin own_m = w; cnt_m = run + 1; end
      else begin own_m = -1; cnt_m = 0; end
    end
  endtask

  // Compare every DUT output against the model a little after input change.
  task automatic settle();
    logic ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #2;
    win_m = mdl_winner();
    ewe = 1'b0; ea = '0; ed = '0;
    if (win_m == 0) begin ewe = m0_we; ea = m0_addr; ed = m0_wdata; end
    else if (win_m == 1) begin ewe = m1_we; ea = m1_addr; ed = m1_wdata; end
    chk("m0_gnt", 64'(m0_gnt), 64'(win_m == 0));
    chk("m1_gnt", 64'(m1_gnt), 64'(win_m == 1));
    chk("ram_wrEn", 64'(ram_wrEn), 64'(ewe));
    chk("ram_addr", 64'(ram_addr), 64'(ea));
    chk("ram_wdata", 64'(ram_wdata), 64'(ed));
    chk("m0_rvalid", 64'(m0_rvalid), 64'(pv[0]));
    chk("m0_rdata", 64'(m0_rdata), pv[0] ? 64'(pd[0]) : 64'h0);
    chk("m1_rvalid", 64'(m1_rvalid), 64'(pv[1]));
    chk("m1_rdata", 64'(m1_rdata), pv[1] ? 64'(pd[1]) : 64'h0);
    if (rst && m0_req && !m0_gnt) wt[0]++; else wt[0] = 0;
    if (rst && m1_req && !m1_gnt) wt[1]++; else wt[1] = 0;
    chk("starve_m0", 64'(wt[0] <= ML), 64'h1);
    chk("starve_m1", 64'(wt[1] <= ML), 64'h1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input bit r0, input bit w0, input bit l0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input bit r1, input bit w1, input bit l1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    settle();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    pl_en = 1'b1; pl_addr = 14'h0005; pl_data = 32'hDEADBEEF;
    mmem[5] = 32'hDEADBEEF;
    set_in(1, 0, 0, 14'h1, 32'h0, 1, 0, 0, 14'h2, 32'h0);
    model_reset();
    @(negedge clk);
    pl_en = 1'b0;
    // Reset gates grants even with both masters requesting
    settle();
    chk("rst_m0_gnt", 64'(m0_gnt), 64'h0);
    chk("rst_m1_gnt", 64'(m1_gnt), 64'h0);
    chk("rst_ram_addr", 64'(ram_addr), 64'h0);
    tick();
    rst = 1'b1;

    // m1 single read of preloaded word
    set_in(0, 0, 0, 14'h0, 32'h0, 1, 0, 0, 14'h0005, 32'h0);
    settle();
    chk("rd_m1_gnt", 64'(m1_gnt), 64'h1);
    chk("rd_ram_addr", 64'(ram_addr), 64'h5);
    tick();
    set_in(0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0);
    settle();
    chk("rd_m1_rvalid", 64'(m1_rvalid), 64'h1);
    chk("rd_m1_rdata", 64'(m1_rdata), 64'hDEADBEEF);
    chk("rd_m0_rvalid", 64'(m0_rvalid), 64'h0);
    chk("rd_m0_rdata", 64'(m0_rdata), 64'h0);
    tick();

    // m0 write to top address, then read it back
    set_in(1, 1, 0, 14'h3FFF, 32'h12345678, 0, 0, 0, 14'h0, 32'h0);
    settle();
    chk("wr_ram_wrEn", 64'(ram_wrEn), 64'h1);
    chk("wr_ram_addr", 64'(ram_addr), 64'h3FFF);
    chk("wr_ram_wdata", 64'(ram_wdata), 64'h12345678);
    tick();
    set_in(1, 0, 0, 14'h3FFF, 32'h0, 0, 0, 0, 14'h0, 32'h0);
    settle();
    chk("wr_no_rvalid", 64'(m0_rvalid), 64'h0);
    tick();
    set_in(0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0);
    settle();
    chk("wr_readback", 64'(m0_rdata), 64'h12345678);
    tick();

    // Conflict without lock alternates from m0
    do_reset();
    set_in(1, 0, 0, 14'h0010, 32'h0, 1, 0, 0, 14'h0020, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_m0_gnt", 64'(m0_gnt), 64'(i % 2 == 0));
      chk("rr_ram_addr", 64'(ram_addr), (i % 2 == 0) ? 64'h10 : 64'h20);
      tick();
    end

    // Lock limit: eight m0 grants, then m1
    do_reset();
    set_in(1, 0, 1, 14'h0002, 32'h0, 1, 0, 0, 14'h0003, 32'h0);
    for (int i = 0; i < 10; i++) begin
      settle();
      if (i <= 8) begin
        chk("lock_m0_gnt", 64'(m0_gnt), 64'(i < 8));
        chk("lock_m1_gnt", 64'(m1_gnt), 64'(i == 8));
      end
      tick();
    end

    // Reset during an outstanding read
    do_reset();
    set_in(0, 0, 0, 14'h0, 32'h0, 1, 0, 0, 14'h0005, 32'h0);
    settle();
    chk("rmr_m1_gnt", 64'(m1_gnt), 64'h1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("rmr_gnt_in_rst", 64'(m1_gnt), 64'h0);
    tick();
    settle();
    chk("rmr_m1_rvalid", 64'(m1_rvalid), 64'h0);
    rst = 1'b1;
    set_in(1, 0, 0, 14'h0007, 32'h0, 1, 0, 0, 14'h0008, 32'h0);
    settle();
    chk("rmr_m0_first", 64'(m0_gnt), 64'h1);
    chk("rmr_m1_wait", 64'(m1_gnt), 64'h0);
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7)), 32'($urandom()),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7)), 32'($urandom()));
        settle();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
